// File: rtl/rpn_stack_ctrl.sv
// RPN stack sequencer: owns stack pointer, single-port stack RAM port and ALU operand registers.
// Latency PUSH 1 / POP 2 / BINOP 3 cycles to done; cmd_ready only in IDLE, requests while busy are dropped.
module rpn_stack_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [1:0]        cmd_alu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_wren,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [1:0]        alu_op,
    input  logic [WIDTH-1:0]  alu_result,
    output logic [WIDTH-1:0]  top,
    output logic [ADDR_W:0]   depth,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {IDLE, WR, RD, LATCH, WB, DONE} state_t;
    typedef enum logic [1:0] {FIN_NONE, FIN_POP1, FIN_CLEAR, FIN_ERR} fin_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_BINOP = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;

    localparam logic [1:0] CODE_OVF = 2'b01;
    localparam logic [1:0] CODE_UNF = 2'b10;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);

    state_t            state;
    fin_t              fin;
    logic              is_pop;
    logic [1:0]        pend_code;
    logic [WIDTH-1:0]  wdata_q;
    logic [ADDR_W:0]   depth_m2;

    assign depth_m2  = depth - TWO;
    assign cmd_ready = (state == IDLE);
    // The ALU result only exists once alu_a is latched, so the write-back data
    // is taken straight from the ALU during WB; every other cycle it is registered.
    assign mem_wdata = (state == WB) ? alu_result : wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fin       <= FIN_NONE;
            is_pop    <= 1'b0;
            pend_code <= 2'b00;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_wren  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'b00;
            top       <= '0;
            depth     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            done     <= 1'b0;
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                done <= 1'b1;
                                if (depth == FULL) begin
                                    state     <= DONE;
                                    fin       <= FIN_ERR;
                                    pend_code <= CODE_OVF;
                                end else begin
                                    state    <= WR;
                                    mem_addr <= depth[ADDR_W-1:0];
                                    wdata_q  <= cmd_data;
                                    mem_wren <= 1'b1;
                                end
                            end
                            OP_BINOP: begin
                                if (depth < TWO) begin
                                    state     <= DONE;
                                    fin       <= FIN_ERR;
                                    pend_code <= CODE_UNF;
                                    done      <= 1'b1;
                                end else begin
                                    state    <= RD;
                                    mem_addr <= depth_m2[ADDR_W-1:0];
                                    alu_b    <= top;
                                    alu_op   <= cmd_alu;
                                    is_pop   <= 1'b0;
                                end
                            end
                            OP_POP: begin
                                if (depth == '0) begin
                                    state     <= DONE;
                                    fin       <= FIN_ERR;
                                    pend_code <= CODE_UNF;
                                    done      <= 1'b1;
                                end else if (depth == ONE) begin
                                    state <= DONE;
                                    fin   <= FIN_POP1;
                                    done  <= 1'b1;
                                end else begin
                                    state    <= RD;
                                    mem_addr <= depth_m2[ADDR_W-1:0];
                                    is_pop   <= 1'b1;
                                end
                            end
                            default: begin
                                state <= DONE;
                                fin   <= FIN_CLEAR;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                WR: begin
                    depth <= depth + ONE;
                    top   <= wdata_q;
                    state <= IDLE;
                end
                RD: begin
                    state <= LATCH;
                    done  <= is_pop;
                end
                LATCH: begin
                    if (is_pop) begin
                        top   <= mem_rdata;
                        depth <= depth - ONE;
                        state <= IDLE;
                    end else begin
                        alu_a    <= mem_rdata;
                        mem_wren <= 1'b1;
                        done     <= 1'b1;
                        state    <= WB;
                    end
                end
                WB: begin
                    top   <= alu_result;
                    depth <= depth - ONE;
                    state <= IDLE;
                end
                DONE: begin
                    case (fin)
                        FIN_POP1: begin
                            depth <= '0;
                            top   <= '0;
                        end
                        FIN_CLEAR: begin
                            depth    <= '0;
                            top      <= '0;
                            err      <= 1'b0;
                            err_code <= 2'b00;
                        end
                        FIN_ERR: begin
                            err <= 1'b1;
                            if (!err) err_code <= pend_code;
                        end
                        default: ;
                    endcase
                    fin   <= FIN_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl with a 4-entry stack, behavioural RAM (1-cycle read) and a 4-op ALU.
module tb_rpn_stack_ctrl;

    localparam int W  = 8;
    localparam int AW = 2;

    logic          clk, reset, cmd_valid, cmd_ready, mem_wren, done, err;
    logic [1:0]    cmd_op, cmd_alu, alu_op, err_code;
    logic [W-1:0]  cmd_data, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, top;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   depth;

    int n_chk = 0;
    int n_fail = 0;

    rpn_stack_ctrl #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_alu(cmd_alu),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .top(top), .depth(depth), .done(done), .err(err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard of expected RAM writes {addr, data}, pushed when the command is driven.
    logic [AW+W-1:0] wq[$];
    always @(negedge clk) begin
        if (mem_wren) begin
            if (wq.size() == 0) begin
                chk("unexpected mem write addr", 32'(mem_addr), 32'hFFFF);
            end else begin
                logic [AW+W-1:0] e;
                e = wq.pop_front();
                chk("mem write", {mem_addr, mem_wdata}, e);
            end
        end
    end

    typedef struct {
        logic [1:0] op; logic [7:0] data; logic [1:0] alu;
        int lat; logic [7:0] top; int dep; logic err; logic [1:0] ec;
        logic wr; logic [1:0] waddr; logic [7:0] wdata;
        logic chk_alu; logic [7:0] a; logic [7:0] b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] op, input logic [7:0] data, input logic [1:0] alu,
                       input int lat, input logic [7:0] t, input int dep, input logic e,
                       input logic [1:0] ec, input logic wr, input logic [1:0] wa,
                       input logic [7:0] wd, input logic ca, input logic [7:0] a,
                       input logic [7:0] b);
        vec_t v;
        v.op = op; v.data = data; v.alu = alu; v.lat = lat; v.top = t; v.dep = dep;
        v.err = e; v.ec = ec; v.wr = wr; v.waddr = wa; v.wdata = wd;
        v.chk_alu = ca; v.a = a; v.b = b;
        tbl.push_back(v);
    endtask

    task automatic run(input vec_t v, input string id);
        int lat, nd, k;
        chk({id, " ready before"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; cmd_alu = v.alu;
        if (v.wr) wq.push_back({v.waddr, v.wdata});
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = 8'($urandom); cmd_alu = 2'($urandom);
        lat = 0; nd = 0; k = 0;
        while (!cmd_ready && k < 12) begin
            if (done) begin
                nd++;
                if (lat == 0) lat = k + 1;
            end
            k++;
            @(negedge clk);
        end
        chk({id, " ready timeout"}, 32'(cmd_ready), 1);
        chk({id, " done latency"}, 32'(lat), 32'(v.lat));
        chk({id, " done pulses"}, 32'(nd), 1);
        chk({id, " top"}, 32'(top), 32'(v.top));
        chk({id, " depth"}, 32'(depth), 32'(v.dep));
        chk({id, " err"}, 32'(err), 32'(v.err));
        chk({id, " err_code"}, 32'(err_code), 32'(v.ec));
        if (v.chk_alu) begin
            chk({id, " alu_a"}, 32'(alu_a), 32'(v.a));
            chk({id, " alu_b"}, 32'(alu_b), 32'(v.b));
        end
    endtask

    localparam logic [1:0] PU = 2'b00, BI = 2'b01, PO = 2'b10, CL = 2'b11;

    initial begin
        int k;
        vec_t v;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_alu = '0;
        //  op  data   alu lat top    dep err ec  wr wa wdata  ca  a      b
        add(PU, 8'h03, 0, 1, 8'h03, 1, 0, 0, 1, 0, 8'h03, 0, 0, 0);
        add(PU, 8'h05, 0, 1, 8'h05, 2, 0, 0, 1, 1, 8'h05, 0, 0, 0);
        add(BI, 8'h00, 0, 3, 8'h08, 1, 0, 0, 1, 0, 8'h08, 1, 8'h03, 8'h05);
        add(PU, 8'h09, 0, 1, 8'h09, 2, 0, 0, 1, 1, 8'h09, 0, 0, 0);
        add(PU, 8'h04, 0, 1, 8'h04, 3, 0, 0, 1, 2, 8'h04, 0, 0, 0);
        add(BI, 8'h00, 1, 3, 8'h05, 2, 0, 0, 1, 1, 8'h05, 1, 8'h09, 8'h04);
        add(PO, 8'h00, 0, 2, 8'h08, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PO, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PO, 8'h00, 0, 1, 8'h00, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(BI, 8'h00, 0, 1, 8'h00, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        add(CL, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PU, 8'h07, 0, 1, 8'h07, 1, 0, 0, 1, 0, 8'h07, 0, 0, 0);
        add(PU, 8'h09, 0, 1, 8'h09, 2, 0, 0, 1, 1, 8'h09, 0, 0, 0);
        add(PO, 8'h00, 0, 2, 8'h07, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PO, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PU, 8'h01, 0, 1, 8'h01, 1, 0, 0, 1, 0, 8'h01, 0, 0, 0);
        add(PU, 8'h02, 0, 1, 8'h02, 2, 0, 0, 1, 1, 8'h02, 0, 0, 0);
        add(PU, 8'h03, 0, 1, 8'h03, 3, 0, 0, 1, 2, 8'h03, 0, 0, 0);
        add(PU, 8'h04, 0, 1, 8'h04, 4, 0, 0, 1, 3, 8'h04, 0, 0, 0);
        add(PU, 8'h05, 0, 1, 8'h04, 4, 1, 1, 0, 0, 0, 0, 0, 0);
        add(BI, 8'h00, 0, 3, 8'h07, 3, 1, 1, 1, 2, 8'h07, 1, 8'h03, 8'h04);
        add(PO, 8'h00, 0, 2, 8'h02, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        add(BI, 8'h00, 1, 3, 8'hFF, 1, 1, 1, 1, 0, 8'hFF, 1, 8'h01, 8'h02);
        add(BI, 8'h00, 0, 1, 8'hFF, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(CL, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(PU, 8'h3C, 0, 1, 8'h3C, 1, 0, 0, 1, 0, 8'h3C, 0, 0, 0);
        add(PU, 8'h36, 0, 1, 8'h36, 2, 0, 0, 1, 1, 8'h36, 0, 0, 0);
        add(BI, 8'h00, 2, 3, 8'h34, 1, 0, 0, 1, 0, 8'h34, 1, 8'h3C, 8'h36);
        add(PU, 8'h81, 0, 1, 8'h81, 2, 0, 0, 1, 1, 8'h81, 0, 0, 0);
        add(BI, 8'h00, 3, 3, 8'hB5, 1, 0, 0, 1, 0, 8'hB5, 1, 8'h34, 8'h81);
        add(PU, 8'h11, 0, 1, 8'h11, 2, 0, 0, 1, 1, 8'h11, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("reset ready", 32'(cmd_ready), 1);
        chk("reset depth", 32'(depth), 0);
        chk("reset top", 32'(top), 0);
        chk("reset mem", {mem_addr, mem_wdata, 7'd0, mem_wren}, 0);
        chk("reset alu", {alu_a, alu_b, 6'd0, alu_op}, 0);
        chk("reset flags", {done, err, err_code}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

        // BINOP add with cmd_valid held high through the busy window: must not queue.
        cmd_valid = 1'b1; cmd_op = BI; cmd_alu = 2'b00;
        wq.push_back({2'd0, 8'hC6});
        @(negedge clk);
        cmd_op = PU; cmd_data = 8'hEE;
        k = 0;
        while (!cmd_ready && k < 12) begin
            k++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("busy-valid ready", 32'(cmd_ready), 1);
        chk("busy-valid depth", 32'(depth), 1);
        chk("busy-valid top", 32'(top), 32'h0C6);
        @(negedge clk);
        chk("busy-valid no extra", 32'(depth), 1);

        // Reset during BINOP LATCH abandons the write-back.
        v = tbl[0]; v.data = 8'h22; v.top = 8'h22; v.dep = 2; v.waddr = 1; v.wdata = 8'h22;
        run(v, "pre-rst push");
        cmd_valid = 1'b1; cmd_op = BI; cmd_alu = 2'b00;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst-latch wren", 32'(mem_wren), 0);
        chk("rst-latch ready", 32'(cmd_ready), 1);
        chk("rst-latch depth", 32'(depth), 0);
        chk("rst-latch top", 32'(top), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst-latch no wren", 32'(mem_wren), 0);
        v = tbl[0]; v.data = 8'h5A; v.top = 8'h5A; v.wdata = 8'h5A;
        run(v, "post-rst push");

        repeat (3) @(negedge clk);
        chk("pending writes", 32'(wq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
